// File: rtl/mp_add_ctrl_pkg.sv
// Shared definitions for the multi-precision add/subtract controller:
// datapath word width, FSM state encoding and the overflow helper.
package mp_add_ctrl_pkg;

    // Width of the single time-shared adder and of every operand word.
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement overflow: both operands share a sign that the
    // result does not. The B input is passed already inverted for subtraction.
    function automatic logic calc_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/mp_add_ctrl_add16.sv
// 16-bit ripple adder with carry-in and carry-out; the controller reuses
// this one instance for every word of the wide operation.
module add16_cin
    import mp_add_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [WORD_W:0] w_full;

    // Widen by one bit so the carry-out falls out of the addition.
    assign w_full = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
    assign sum    = w_full[WORD_W-1:0];
    assign cout   = w_full[WORD_W];

endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-precision adder/subtractor. Operands of N_WORDS 16-bit words are
// processed LSW first through one shared 16-bit adder, one word per cycle.
// Results and flags are registered and held until the next done pulse.
module mp_add_ctrl
    import mp_add_ctrl_pkg::*;
#(
    parameter int N_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      op_sub,
    input  logic [WORD_W*N_WORDS-1:0] a,
    input  logic [WORD_W*N_WORDS-1:0] b,
    output logic                      busy,
    output logic                      done,
    output logic [WORD_W*N_WORDS-1:0] sum,
    output logic                      cout,
    output logic                      zero,
    output logic                      sign,
    output logic                      parity,
    output logic                      overflow
);

    localparam int W       = WORD_W * N_WORDS;
    localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int TOP_LSB = (N_WORDS - 1) * WORD_W;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N_WORDS - 1);

    state_t            r_state;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;        // B already inverted when subtracting
    logic [W-1:0]      r_work;
    logic              r_carry;
    logic [CNT_W-1:0]  r_k;
    logic              r_busy;
    logic              r_done;
    logic [W-1:0]      r_sum;
    logic              r_cout;
    logic              r_zero;
    logic              r_sign;
    logic              r_parity;
    logic              r_overflow;

    logic [WORD_W-1:0] w_a_word;
    logic [WORD_W-1:0] w_b_word;
    logic [WORD_W-1:0] w_add_sum;
    logic              w_add_cout;
    logic [W-1:0]      w_final;

    assign w_a_word = r_a[r_k*WORD_W +: WORD_W];
    assign w_b_word = r_b[r_k*WORD_W +: WORD_W];

    add16_cin u_add16 (
        .a    (w_a_word),
        .b    (w_b_word),
        .cin  (r_carry),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    // Full result as it will look once the top word is written, so the
    // outputs can load in the same edge that computes the last word.
    always_comb begin
        w_final = r_work;
        w_final[TOP_LSB +: WORD_W] = w_add_sum;
    end

    // Controller FSM, working registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_work     <= '0;
            r_carry    <= 1'b0;
            r_k        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_zero     <= 1'b0;
            r_sign     <= 1'b0;
            r_parity   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE behaves like IDLE for acceptance, enabling back-to-back ops.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= op_sub ? ~b : b;
                        r_carry <= op_sub;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ADD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    r_work[r_k*WORD_W +: WORD_W] <= w_add_sum;
                    r_carry <= w_add_cout;
                    if (r_k == K_LAST) begin
                        r_k        <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                        r_sum      <= w_final;
                        r_cout     <= w_add_cout;
                        r_zero     <= (w_final == '0);
                        r_sign     <= w_final[W-1];
                        r_parity   <= ~^w_final;
                        r_overflow <= calc_ovf(r_a[W-1], r_b[W-1], w_add_sum[WORD_W-1]);
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign zero     = r_zero;
    assign sign     = r_sign;
    assign parity   = r_parity;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_mp_add_ctrl.sv
// Self-checking bench for mp_add_ctrl with N_WORDS=4 (64-bit operands).
module tb_mp_add_ctrl;

    localparam int NW = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        cout;
    logic        zero;
    logic        sign;
    logic        parity;
    logic        overflow;

    int total;
    int bad;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        zero;
        logic        sign;
        logic        parity;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        res_t        exp;
    } vec_t;

    mp_add_ctrl #(.N_WORDS(NW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .zero     (zero),
        .sign     (sign),
        .parity   (parity),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain 65-bit arithmetic on signed/unsigned interpretations.
    function automatic res_t model(input logic [63:0] va, input logic [63:0] vb,
                                   input logic vs);
        res_t        r;
        logic [64:0] full;
        longint      sa, sb, sr;
        full     = vs ? ({1'b0, va} - {1'b0, vb}) : ({1'b0, va} + {1'b0, vb});
        r.sum    = full[63:0];
        // For subtraction the carry means "no borrow", i.e. a >= b unsigned.
        r.cout   = vs ? (va >= vb) : full[64];
        r.zero   = (r.sum == 64'd0);
        r.sign   = r.sum[63];
        r.parity = ($countones(r.sum) % 2) == 0;
        sa = longint'(va);
        sb = longint'(vb);
        sr = longint'(r.sum);
        if (vs) r.ovf = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
        else    r.ovf = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input res_t e);
        chk({nm, " sum"},      sum,             e.sum);
        chk({nm, " cout"},     64'(cout),       64'(e.cout));
        chk({nm, " zero"},     64'(zero),       64'(e.zero));
        chk({nm, " sign"},     64'(sign),       64'(e.sign));
        chk({nm, " parity"},   64'(parity),     64'(e.parity));
        chk({nm, " overflow"}, 64'(overflow),   64'(e.ovf));
    endtask

    // One complete operation from idle, checking cycle-exact busy/done timing.
    task automatic run_op(input logic [63:0] va, input logic [63:0] vb,
                          input logic vs, input res_t e, input string nm);
        @(negedge clk);
        a = va; b = vb; op_sub = vs; start = 1'b1;
        @(posedge clk);                        // edge T: accepted
        for (int i = 1; i <= NW; i++) begin
            @(negedge clk);                    // cycle T+i
            start = 1'b0;
            chk({nm, " busy"}, 64'(busy), 64'd1);
            chk({nm, " done_early"}, 64'(done), 64'd0);
        end
        @(negedge clk);                        // cycle T+NW+1
        chk({nm, " done"}, 64'(done), 64'd1);
        chk({nm, " busy_done"}, 64'(busy), 64'd0);
        chk_res(nm, e);
        $display("op %s a=%h b=%h sub=%0d sum=%h c=%0d z=%0d s=%0d p=%0d v=%0d",
                 nm, va, vb, vs, sum, cout, zero, sign, parity, overflow);
        @(negedge clk);
        chk({nm, " done_pulse"}, 64'(done), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        res_t e1, e2;
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;

        vecs[0] = '{64'h0, 64'h0, 1'b0,
                    '{64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                    '{64'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                    '{64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}};
        vecs[3] = '{64'h5, 64'h7, 1'b1,
                    '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[4] = '{64'h1, 64'h1, 1'b1,
                    '{64'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1,
                    '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk_res("reset", '{64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp, $sformatf("vec%0d", i));

        // Results stay held while idle
        repeat (4) @(negedge clk);
        chk_res("hold_idle", vecs[5].exp);
        chk("hold_idle done", 64'(done), 64'd0);

        // Randomized operations against the model
        for (int i = 0; i < 20; i++) begin
            logic [63:0] ra, rb;
            logic        rs;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 5 == 1) rb = ra;
            if (i % 5 == 2) ra[63:16] = '1;
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, model(ra, rb, rs), $sformatf("rnd%0d", i));
        end

        // start during an operation is ignored
        e1 = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        @(negedge clk);
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);                                  // edge T
        @(negedge clk); start = 1'b0;                    // cycle T+1
        @(negedge clk);                                  // cycle T+2
        a = 64'hDEAD_BEEF_0000_1111; b = 64'h5555_AAAA_5555_AAAA; op_sub = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;                    // cycle T+3
        @(negedge clk);                                  // cycle T+4
        chk("ign busy", 64'(busy), 64'd1);
        chk("ign done_early", 64'(done), 64'd0);
        @(negedge clk);                                  // cycle T+5
        chk("ign done", 64'(done), 64'd1);
        chk_res("ign", e1);
        $display("op ignore-start sum=%h", sum);
        @(negedge clk);
        chk("ign no_queue busy", 64'(busy), 64'd0);
        chk("ign no_queue done", 64'(done), 64'd0);

        // Reset mid-ADD aborts without a done pulse
        @(negedge clk);
        a = 64'h0000_1111_2222_3333; b = 64'h4444_5555_6666_7777; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid busy", 64'(busy), 64'd0);
        chk("rst_mid done", 64'(done), 64'd0);
        chk_res("rst_mid", '{64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid no_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        $display("op reset-abort sum=%h busy=%0d", sum, busy);
        run_op(64'h0000_0000_FFFF_0001, 64'h0000_0000_0001_FFFF, 1'b1,
               model(64'h0000_0000_FFFF_0001, 64'h0000_0000_0001_FFFF, 1'b1), "post_rst");

        // Back-to-back: start held in the DONE cycle
        e1 = model(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0);
        e2 = model(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0009, 1'b1);
        @(negedge clk);
        a = 64'hAAAA_BBBB_CCCC_DDDD; b = 64'h1111_2222_3333_4444; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (NW) @(negedge clk);                      // first done cycle
        chk("b2b done1", 64'(done), 64'd1);
        chk_res("b2b first", e1);
        a = 64'h3; b = 64'h9; op_sub = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 1; i < NW + 1; i++) begin
            if (i > 1) @(negedge clk);
            chk("b2b gap done", 64'(done), 64'd0);
            chk("b2b held sum", sum, e1.sum);
        end
        @(negedge clk);                                  // 5 cycles after first done
        chk("b2b done2", 64'(done), 64'd1);
        chk_res("b2b second", e2);
        $display("op back-to-back sum1=%h sum2=%h", e1.sum, sum);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mp_add_ctrl.md
MP_ADD_CTRL -- requirements
Module: mp_add_ctrl

Interface
REQ-001 Parameter: N_WORDS, 4, number of 16-bit words per operand; legal range 2..8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only when busy=0.
REQ-005 op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  16*N_WORDS  operand A; sampled with start.
REQ-007 b  input  16*N_WORDS  operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when results update.
REQ-010 sum  output  16*N_WORDS  result, held until the next done.
REQ-011 cout, zero, sign, parity, overflow  output  1 each  result flags, held with sum.

Function
REQ-012 The block SHALL compute the wide sum using exactly one 16-bit adder with carry-in, time-shared across words, LSW first.
REQ-013 FSM states SHALL be IDLE, ADD, DONE; reset enters IDLE.
REQ-014 IDLE: start=1 latches a, b, op_sub; word counter cleared; carry seeded with op_sub; -> ADD.
REQ-015 ADD: each cycle adds word k of A and word k of (op_sub ? ~B : B) plus the stored carry, stores word k and carry-out, increments k; after word N_WORDS-1 -> DONE.
REQ-016 DONE: done=1 for exactly one cycle; sum and flags outputs load from the working registers on that cycle; -> ADD if start=1 (back-to-back, new operands latched), else -> IDLE.
REQ-017 busy SHALL be 1 in ADD, 0 in IDLE and DONE.
REQ-018 Latency: with start accepted at edge T, done=1 and the new results are visible during cycle T+N_WORDS+1.
REQ-019 start while busy=1 SHALL be ignored (no queuing, no operand capture).
REQ-020 cout SHALL be the carry-out of the top word (for subtraction, 1 = no borrow).
REQ-021 zero SHALL be 1 iff all 16*N_WORDS result bits are 0; sign SHALL be the result MSB.
REQ-022 parity SHALL be 1 iff the result has an even number of ones.
REQ-023 overflow SHALL be two's-complement overflow of the full-width operation, from the top word's operand MSBs (B inverted for subtraction) and result MSB.
REQ-024 sum and the flags SHALL NOT change except on the done cycle or at reset.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, busy=0, done=0, sum=0, and all flags 0, and clear the working registers and counter.
REQ-026 Reset during ADD SHALL abort the operation with no done pulse; the first start after release behaves as from power-up.

Structure
REQ-027 The FSM state encoding and the word width constant (16) SHALL live in a shared package.
REQ-028 One sub-module, add16_cin, SHALL implement the 16-bit adder with carry-in and carry-out; the controller SHALL instantiate it exactly once.

Verification (N_WORDS=4)
REQ-029 Bench SHALL drive a=0, b=0, add, start at T -> busy=1 on cycles T+1..T+4; done at T+5; sum=0; zero=1; parity=1; cout=0; overflow=0.
REQ-030 Bench SHALL drive a=64'hFFFF_FFFF_FFFF_FFFF, b=1, add -> sum=0, cout=1, zero=1, overflow=0; this exercises carry across every word boundary.
REQ-031 Bench SHALL drive a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=64'h8000_0000_0000_0000, sign=1, overflow=1, parity=0, cout=0.
REQ-032 Bench SHALL drive a=5, b=7, sub -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, sign=1, parity=0, overflow=0.
REQ-033 Bench SHALL pulse start with new operands at T+2 during an operation -> it is ignored and the first result is unchanged; then assert rst_n=0 mid-ADD of a second operation -> outputs are 0 at once and no done occurs.
REQ-034 Bench SHALL hold start=1 with new operands in the DONE cycle -> the second result's done arrives exactly 5 cycles after the first done, and the first result stays held until then.
